// File: rtl/signed_div_pkg.sv
// rtl/signed_div_pkg.sv - shared state encoding and default sizes for signed_div_ctrl
package signed_div_pkg;

  localparam int DEF_BITSIZE = 16;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_OUT
  } state_e;

endpackage

// File: rtl/div_req_fifo.sv
// rtl/div_req_fifo.sv - synchronous request FIFO holding {dividend, divisor}
module div_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/signed_div_ctrl.sv
// rtl/signed_div_ctrl.sv - signed front end for an external unsigned divider
module signed_div_ctrl
  import signed_div_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] in_dividend,
  input  logic [BITSIZE-1:0] in_divisor,
  output logic               div_strt,
  output logic [BITSIZE-1:0] div_dividend,
  output logic [BITSIZE-1:0] div_divisor,
  input  logic               div_idle,
  input  logic [BITSIZE-1:0] div_quotient,
  input  logic [BITSIZE-1:0] div_remainder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] out_quotient,
  output logic [BITSIZE-1:0] out_remainder,
  output logic               out_dbz,
  output logic               out_ovf
);

  localparam int                 MSB      = BITSIZE - 1;
  localparam logic [BITSIZE-1:0] MOST_NEG = {1'b1, {(BITSIZE-1){1'b0}}};

  state_e             state_q;
  logic               div_strt_q;
  logic               out_valid_q;
  logic               out_dbz_q;
  logic               out_ovf_q;
  logic [BITSIZE-1:0] out_quotient_q;
  logic [BITSIZE-1:0] out_remainder_q;

  logic               push;
  logic               pop;
  logic               has_req;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*BITSIZE-1:0] head_data;
  logic [BITSIZE-1:0] head_dividend;
  logic [BITSIZE-1:0] head_divisor;

  logic [BITSIZE-1:0] res_quotient_d;
  logic [BITSIZE-1:0] res_remainder_d;
  logic               res_dbz_d;
  logic               res_ovf_d;

  function automatic logic [BITSIZE-1:0] magnitude(input logic [BITSIZE-1:0] v);
    return v[MSB] ? -v : v;
  endfunction

  div_req_fifo #(
    .WIDTH (2*BITSIZE),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_dividend, in_divisor}),
    .rdata_o (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_dividend, head_divisor} = head_data;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // A push in this cycle counts as pending work so an idle controller issues next cycle.
  assign has_req  = !fifo_empty || push;
  // The head stays in the FIFO while in flight so the divider operands stay stable.
  assign pop      = (state_q == ST_WAIT_DONE) && div_idle;

  assign div_dividend = magnitude(head_dividend);
  assign div_divisor  = magnitude(head_divisor);

  always_comb begin
    res_dbz_d       = (head_divisor == '0);
    res_ovf_d       = (head_dividend == MOST_NEG) && (head_divisor == '1);
    res_quotient_d  = (head_dividend[MSB] ^ head_divisor[MSB]) ? -div_quotient : div_quotient;
    res_remainder_d = head_dividend[MSB] ? -div_remainder : div_remainder;
    if (res_dbz_d) begin
      res_quotient_d  = '1;
      res_remainder_d = head_dividend;
    end else if (res_ovf_d) begin
      res_quotient_d  = MOST_NEG;
      res_remainder_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      div_strt_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_dbz_q       <= 1'b0;
      out_ovf_q       <= 1'b0;
      out_quotient_q  <= '0;
      out_remainder_q <= '0;
    end else begin
      div_strt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (has_req && div_idle) begin
            state_q    <= ST_ISSUE;
            div_strt_q <= 1'b1;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: begin
          if (!div_idle) state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (div_idle) begin
            state_q         <= ST_OUT;
            out_valid_q     <= 1'b1;
            out_quotient_q  <= res_quotient_d;
            out_remainder_q <= res_remainder_d;
            out_dbz_q       <= res_dbz_d;
            out_ovf_q       <= res_ovf_d;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (has_req) begin
              state_q    <= ST_ISSUE;
              div_strt_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign div_strt      = div_strt_q;
  assign out_valid     = out_valid_q;
  assign out_quotient  = out_quotient_q;
  assign out_remainder = out_remainder_q;
  assign out_dbz       = out_dbz_q;
  assign out_ovf       = out_ovf_q;

endmodule

// File: tb/tb_signed_div_ctrl.sv
// tb/tb_signed_div_ctrl.sv - scoreboard bench for signed_div_ctrl with a behavioural divider
module tb_signed_div_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         div_strt;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic         div_idle;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_dbz;
  logic         out_ovf;

  int   checks = 0;
  int   errors = 0;
  int   strt_cnt = 0;
  int   res_cnt = 0;
  bit   rand_ready = 0;
  exp_t exp_q[$];

  signed_div_ctrl #(.BITSIZE(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_strt      (div_strt),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_idle      (div_idle),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz),
    .out_ovf       (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz, input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
    return e;
  endfunction

  // Signed arithmetic reference: truncating division, remainder takes the dividend sign.
  function automatic exp_t ref_div(input logic [W-1:0] a_u, input logic [W-1:0] b_u);
    int a;
    int b;
    a = int'($signed(a_u));
    b = int'($signed(b_u));
    if (b == 0)                      return mk('1, a_u, 1'b1, 1'b0);
    if (a == -(1 << (W-1)) && b == -1) return mk(a_u, '0, 1'b0, 1'b1);
    return mk(W'(a / b), W'(a % b), 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit done;
    done = 0;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: request %0h/%0h not accepted within 300 cycles", a, b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    send(a, b, ref_div(a, b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding after 3000 cycles, expected 0", exp_q.size());
    end
    tick();
  endtask

  // Behavioural unsigned divider: busy for 4..8 cycles after each start pulse.
  initial begin
    logic [W-1:0] dv_a;
    logic [W-1:0] dv_b;
    int           dv_cnt;
    bit           dv_busy;
    dv_a = '0; dv_b = '0; dv_cnt = 0; dv_busy = 0;
    div_idle = 1'b1;
    div_quotient = '0;
    div_remainder = '0;
    forever begin
      tick();
      if (rst) begin
        dv_busy  = 0;
        div_idle = 1'b1;
      end else if (dv_busy) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          checks++;
          if (div_dividend !== dv_a || div_divisor !== dv_b) begin
            errors++;
            $display("FAIL div_operands_stable: got %0h/%0h expected %0h/%0h",
                     div_dividend, div_divisor, dv_a, dv_b);
          end
          if (dv_b == '0) begin
            div_quotient  = '1;
            div_remainder = dv_a;
          end else begin
            div_quotient  = dv_a / dv_b;
            div_remainder = dv_a % dv_b;
          end
          dv_busy  = 0;
          div_idle = 1'b1;
        end
      end else if (div_strt) begin
        dv_a     = div_dividend;
        dv_b     = div_divisor;
        dv_cnt   = int'($urandom_range(4, 8));
        dv_busy  = 1;
        div_idle = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks hold / start rules.
  initial begin
    exp_t         e;
    bit           prev_hold;
    bit           prev_strt;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    logic         hd;
    logic         ho;
    prev_hold = 0; prev_strt = 0;
    hq = '0; hr = '0; hd = 1'b0; ho = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 0;
        prev_strt = 0;
      end else begin
        if (div_strt) begin
          strt_cnt++;
          checks++;
          if (prev_strt || out_valid) begin
            errors++;
            $display("FAIL strt_pulse: got prev_strt=%0b out_valid=%0b expected both 0",
                     prev_strt, out_valid);
          end
        end
        prev_strt = div_strt;
        if (prev_hold) begin
          checks++;
          if (!out_valid || out_quotient !== hq || out_remainder !== hr ||
              out_dbz !== hd || out_ovf !== ho) begin
            errors++;
            $display("FAIL hold: got v=%0b q=%h r=%h dbz=%b ovf=%b expected v=1 q=%h r=%h dbz=%b ovf=%b",
                     out_valid, out_quotient, out_remainder, out_dbz, out_ovf, hq, hr, hd, ho);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          res_cnt++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got q=%h r=%h with no request outstanding",
                     out_quotient, out_remainder);
          end else begin
            e = exp_q.pop_front();
            if (out_quotient !== e.q || out_remainder !== e.r ||
                out_dbz !== e.dbz || out_ovf !== e.ovf) begin
              errors++;
              $display("FAIL result%0d: got q=%h r=%h dbz=%b ovf=%b expected q=%h r=%h dbz=%b ovf=%b",
                       res_cnt, out_quotient, out_remainder, out_dbz, out_ovf,
                       e.q, e.r, e.dbz, e.ovf);
            end
          end
        end
        prev_hold = out_valid && !out_ready;
        hq = out_quotient; hr = out_remainder; hd = out_dbz; ho = out_ovf;
      end
    end
  end

  initial begin
    int s0;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    out_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),      32'd1);
    chk("rst_div_strt",  32'(div_strt),      32'd0);
    chk("rst_out_valid", 32'(out_valid),     32'd0);
    chk("rst_out_dbz",   32'(out_dbz),       32'd0);
    chk("rst_out_ovf",   32'(out_ovf),       32'd0);
    chk("rst_out_q",     32'(out_quotient),  32'd0);
    chk("rst_out_r",     32'(out_remainder), 32'd0);
    rst = 1'b0;
    tick();

    // 100/7 with latency checks on issue and on result
    s0 = strt_cnt;
    send(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0));
    @(negedge clk);
    chk("issue_latency", 32'(div_strt), 32'd1);
    n = 0;
    while (!div_idle && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("out_latency", 32'(out_valid), 32'd1);
    drain();
    chk("strt_count_single", 32'(strt_cnt - s0), 32'd1);

    // Sign combinations back to back
    s0 = strt_cnt;
    send(16'(-100), 16'd7,     mk(16'(-14), 16'(-2), 1'b0, 1'b0));
    send(16'd100,   16'(-7),   mk(16'(-14), 16'd2,   1'b0, 1'b0));
    send(16'(-100), 16'(-7),   mk(16'd14,   16'(-2), 1'b0, 1'b0));
    drain();
    chk("strt_count_signs", 32'(strt_cnt - s0), 32'd3);

    // Overflow and divide by zero
    send(16'h8000, 16'hFFFF, mk(16'h8000, 16'd0, 1'b0, 1'b1));
    send(16'd5,    16'd0,    mk(16'hFFFF, 16'd5, 1'b1, 1'b0));
    drain();

    // Back-pressure: five requests while the consumer stalls
    out_ready = 1'b0;
    s0 = strt_cnt;
    for (int i = 0; i < 5; i++) send_ref(16'(1000 + 37 * i), 16'(3 + i));
    repeat (20) tick();
    @(negedge clk);
    chk("bp_in_ready_low",  32'(in_ready),          32'd0);
    chk("bp_out_valid",     32'(out_valid),         32'd1);
    chk("bp_single_issue",  32'(strt_cnt - s0),     32'd1);
    tick();
    out_ready = 1'b1;
    drain();
    chk("bp_strt_total", 32'(strt_cnt - s0), 32'd5);

    // Reset while the head is in WAIT_DONE with two more queued
    send_ref(16'd1234, 16'd11);
    send_ref(16'd4321, 16'd13);
    send_ref(16'd999,  16'd7);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = strt_cnt;
    n = res_cnt;
    repeat (30) tick();
    chk("midrst_no_issue",  32'(strt_cnt - s0), 32'd0);
    chk("midrst_no_result", 32'(res_cnt - n),   32'd0);
    send(16'd9, 16'd3, mk(16'd3, 16'd0, 1'b0, 1'b0));
    drain();

    // Randomised traffic with corner operands and random consumer stalls
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           sel;
      sel = int'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if (sel == 0)      b = '0;
      else if (sel == 1) begin a = 16'h8000; b = 16'hFFFF; end
      else if (sel == 2) b = 16'($urandom_range(1, 15));
      else if (sel == 3) b = -16'($urandom_range(1, 15));
      else if (sel == 4) a = 16'h8000;
      send_ref(a, b);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rand_ready = 0;
    tick();
    out_ready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signed_div_ctrl.md
SIGNED_DIV_CTRL -- requirements
Module: signed_div_ctrl

Interface
REQ-001 The block SHALL have parameter BITSIZE, default 16, giving the operand/result width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the request FIFO depth (power of two, minimum 2).
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  a signed request is presented.
REQ-006 in_ready  output  1  the request FIFO can accept a request.
REQ-007 in_dividend  input  BITSIZE  two's-complement dividend.
REQ-008 in_divisor  input  BITSIZE  two's-complement divisor.
REQ-009 div_strt  output  1  start pulse to the unsigned divider.
REQ-010 div_dividend  output  BITSIZE  unsigned magnitude of the dividend to the divider.
REQ-011 div_divisor  output  BITSIZE  unsigned magnitude of the divisor to the divider.
REQ-012 div_idle  input  1  divider idle indication.
REQ-013 div_quotient  input  BITSIZE  unsigned quotient from the divider.
REQ-014 div_remainder  input  BITSIZE  unsigned remainder from the divider.
REQ-015 out_valid  output  1  a signed result is held on the outputs.
REQ-016 out_ready  input  1  the consumer accepts the result.
REQ-017 out_quotient  output  BITSIZE  signed quotient.
REQ-018 out_remainder  output  BITSIZE  signed remainder.
REQ-019 out_dbz  output  1  divide by zero.
REQ-020 out_ovf  output  1  overflow (most-negative value divided by -1).

Function
REQ-021 A request SHALL be pushed when in_valid and in_ready are both high; in_ready SHALL be the FIFO not-full flag only and SHALL stay low while the FIFO is full, even in a cycle with a pop.
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and OUT.
REQ-023 IDLE -> ISSUE when the FIFO is non-empty and div_idle=1.
REQ-024 In ISSUE, div_strt SHALL be 1 for exactly one cycle, then the FSM goes to WAIT_BUSY.
REQ-025 WAIT_BUSY -> WAIT_DONE on the first cycle with div_idle=0.
REQ-026 WAIT_DONE -> OUT on the first cycle with div_idle=1; in that same cycle the FSM SHALL capture the sign-corrected result into the output registers and pop the FIFO head.
REQ-027 OUT -> ISSUE, or -> IDLE if the FIFO is empty, in the cycle out_valid and out_ready are both high; no new div_strt SHALL issue while out_valid=1.
REQ-028 div_dividend and div_divisor SHALL be driven from the FIFO head magnitudes and held stable from ISSUE through WAIT_DONE.
REQ-029 Magnitude SHALL be the BITSIZE-bit two's-complement negation for negative inputs, so the most negative value maps to 2^(BITSIZE-1).
REQ-030 Quotient sign SHALL be dividend sign XOR divisor sign, with truncation toward zero.
REQ-031 Remainder sign SHALL follow the dividend sign, so that dividend = divisor*quotient + remainder.
REQ-032 A zero divisor SHALL still be issued; the result SHALL be out_dbz=1, out_quotient=all ones, out_remainder=in_dividend, out_ovf=0.
REQ-033 A dividend of -2^(BITSIZE-1) with divisor -1 SHALL give out_ovf=1, out_quotient=-2^(BITSIZE-1) (wrapped), out_remainder=0.
REQ-034 out_valid, out_quotient, out_remainder, out_dbz and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-035 Minimum latency SHALL be: FIFO empty and IDLE, push in cycle N -> ISSUE in cycle N+1; out_valid in the cycle after div_idle returns to 1.

Reset
REQ-036 On rst the FSM SHALL go to IDLE and the FIFO SHALL flush, with in_ready=1, div_strt=0, out_valid=0, out_dbz=0, out_ovf=0, out_quotient=0 and out_remainder=0.
REQ-037 Reset mid-operation SHALL discard the in-flight and queued requests without emitting a result; the divider shares rst.

Structure
REQ-038 A shared package signed_div_pkg SHALL hold the FSM state encoding and the default BITSIZE and DEPTH constants.
REQ-039 The request FIFO SHALL be a sub-module div_req_fifo (synchronous, storing {dividend, divisor}, with full and empty flags).
REQ-040 The divider SHALL NOT be instantiated inside this block; it SHALL be connected at the parent level.

Verification
REQ-041 Request 100/7 -> out_quotient=14, out_remainder=2, flags 0.
REQ-042 Requests -100/7, 100/-7 and -100/-7 back-to-back -> (-14,-2), (-14,2), (14,-2) in order, exactly one div_strt each.
REQ-043 Request 0x8000/0xFFFF (BITSIZE=16) -> out_ovf=1, out_quotient=0x8000, out_remainder=0; request 5/0 -> out_dbz=1, out_quotient=0xFFFF, out_remainder=5.
REQ-044 5 pushes with out_ready=0 -> in_ready low after 4 queued, out_valid and first result held stable; release out_ready -> all 5 results delivered in order.
REQ-045 rst asserted during WAIT_DONE with 2 queued -> out_valid=0, in_ready=1, no result emitted after release; a following request 9/3 -> out_quotient=3, out_remainder=0.
